// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receive controller: start-bit qualification, mid-bit data
// sampling, stop-bit check and a valid/rd handoff with sticky error flags.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 rx_in,
    input  logic                 rd,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state, state_nx;
    logic                   rx_p0, rx_s_p1;
    logic                   rx_s;
    logic [CNT_W-1:0]       tick_cnt, tick_nx;
    logic [IDX_W-1:0]       bit_idx, bit_nx;
    logic [DATA_BITS-1:0]   shreg, shreg_nx;
    logic                   deliver;
    logic                   ferr_set;
    logic                   ovr_set;

    assign rx_s    = rx_s_p1;
    assign busy    = (state != IDLE);
    assign ovr_set = deliver && valid && !rd;

    always_comb begin
        state_nx = state;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        deliver  = 1'b0;
        ferr_set = 1'b0;
        if (state == IDLE || state == WAIT_HIGH || tick_cnt == BIT_LAST) begin
            tick_nx = '0;
        end else begin
            tick_nx = tick_cnt + CNT_W'(1);
        end

        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) state_nx = START;
                end
                START: begin
                    // A line that is high again at mid start bit was only a glitch.
                    if (tick_cnt == HALF_LAST) begin
                        state_nx = rx_s ? IDLE : DATA;
                        bit_nx   = '0;
                    end
                end
                DATA: begin
                    if (tick_cnt == BIT_LAST) begin
                        shreg_nx[bit_idx] = rx_s;
                        if (bit_idx == LAST_IDX) state_nx = STOP;
                        else                     bit_nx   = bit_idx + IDX_W'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt == BIT_LAST) begin
                        if (rx_s) begin
                            deliver  = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            ferr_set = 1'b1;
                            state_nx = WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end

        if (state_nx != state) tick_nx = '0;
    end

    // Stage boundary: synchroniser, control state and host-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_p0     <= 1'b1;
            rx_s_p1   <= 1'b1;
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_p0    <= rx_in;
            rx_s_p1  <= rx_p0;
            state    <= state_nx;
            tick_cnt <= tick_nx;
            bit_idx  <= bit_nx;
            // A same-cycle rd frees the slot, so the new byte lands without overrun.
            if (deliver && (!valid || rd)) begin
                data_out <= shreg;
                valid    <= 1'b1;
            end else if (rd) begin
                valid <= 1'b0;
            end
            frame_err <= ferr_set || (frame_err && !err_clr);
            overrun   <= ovr_set  || (overrun   && !err_clr);
        end
    end

    // Stage boundary: assembly register, never read before all bits are written
    always_ff @(posedge clk) begin
        shreg <= shreg_nx;
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: time-based receiver model checked every cycle, plus
// literal expectations at the end of each directed scenario.
module tb_uart_rx_ctrl;

    localparam int CPB  = 8;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic       rx_in = 1'b1;
    logic       rd = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data_out;
    logic       valid, busy, frame_err, overrun;

    int checks = 0;
    int failures = 0;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rx_in(rx_in), .rd(rd),
        .err_clr(err_clr), .data_out(data_out), .valid(valid), .busy(busy),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Model: frame position is the elapsed clock count since the start was seen.
    logic [1:0] m_sync = 2'b11;
    logic       m_on = 1'b0, m_brk = 1'b0;
    int         m_t0 = 0, m_cyc = 0;
    logic [7:0] m_bits = 8'h00, m_data = 8'h00;
    logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

    task automatic model_step();
        logic rs, dl, fset, oset;
        int   e, k;
        if (reset) begin
            m_sync = 2'b11; m_on = 1'b0; m_brk = 1'b0;
            m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0;
            return;
        end
        rs = m_sync[1];
        m_sync = {m_sync[0], rx_in};
        dl = 1'b0;
        fset = 1'b0;
        if (!enable) begin
            m_on = 1'b0;
            m_brk = 1'b0;
        end else if (m_brk) begin
            if (rs) m_brk = 1'b0;
        end else if (m_on) begin
            e = m_cyc - m_t0;
            if (e == HALF) begin
                if (rs) m_on = 1'b0;
            end else if (e > HALF && (e - HALF) % CPB == 0) begin
                k = (e - HALF) / CPB;
                if (k <= 8) begin
                    m_bits[k-1] = rs;
                end else begin
                    m_on = 1'b0;
                    if (rs) dl = 1'b1;
                    else begin
                        fset = 1'b1;
                        m_brk = 1'b1;
                    end
                end
            end
        end else if (!rs) begin
            m_on = 1'b1;
            m_t0 = m_cyc;
        end
        oset = dl && m_valid && !rd;
        if (dl && (!m_valid || rd)) begin
            m_data = m_bits;
            m_valid = 1'b1;
        end else if (rd) begin
            m_valid = 1'b0;
        end
        m_ferr = fset || (m_ferr && !err_clr);
        m_ovr  = oset || (m_ovr && !err_clr);
        m_cyc++;
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // Literal expectations posted by the stimulus process.
    string      lit_name = "";
    logic       lit_v = 1'b0, lit_f = 1'b0, lit_o = 1'b0, lit_b = 1'b0;
    logic [7:0] lit_d = 8'h00;
    int         lit_seq = 0;
    int         lit_seen = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        wait (reset == 1'b1);
        forever begin
            @(negedge clk);
            chk("cyc_valid",     {7'b0, valid},     {7'b0, m_valid});
            chk("cyc_data_out",  data_out,          m_data);
            chk("cyc_busy",      {7'b0, busy},      {7'b0, m_on || m_brk});
            chk("cyc_frame_err", {7'b0, frame_err}, {7'b0, m_ferr});
            chk("cyc_overrun",   {7'b0, overrun},   {7'b0, m_ovr});
            if (lit_seq != lit_seen) begin
                lit_seen = lit_seq;
                chk({lit_name, "_valid"},     {7'b0, valid},     {7'b0, lit_v});
                chk({lit_name, "_data_out"},  data_out,          lit_d);
                chk({lit_name, "_frame_err"}, {7'b0, frame_err}, {7'b0, lit_f});
                chk({lit_name, "_overrun"},   {7'b0, overrun},   {7'b0, lit_o});
                chk({lit_name, "_busy"},      {7'b0, busy},      {7'b0, lit_b});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_lit(input string nm, input logic v, input logic [7:0] d,
                              input logic f, input logic o, input logic b);
        lit_name = nm; lit_v = v; lit_d = d; lit_f = f; lit_o = o; lit_b = b;
        lit_seq++;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // 8N1 frame; rd pulses at bit-time rd_tick, the frame is cut short at cut_tick.
    task automatic send_frame(input logic [7:0] d, input logic stopb,
                              input int rd_tick, input int cut_tick);
        logic [9:0] fr;
        fr = {stopb, d, 1'b0};
        for (int t = 0; t < 10 * CPB; t++) begin
            if (t == cut_tick) begin
                rd = 1'b0;
                return;
            end
            rx_in = fr[t / CPB];
            rd = (t == rd_tick);
            tick(1);
        end
        rd = 1'b0;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b1;
        tick(3);
        expect_lit("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(4);

        send_frame(8'hA5, 1'b1, -1, -1);
        expect_lit("t1_rx", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        pulse_rd();
        expect_lit("t1_rd", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);

        rx_in = 1'b0;
        tick(3);
        rx_in = 1'b1;
        tick(3);
        expect_lit("t2_in_start", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        expect_lit("t2_reject", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);

        send_frame(8'h3C, 1'b0, -1, -1);
        tick(40);
        expect_lit("t3_break", 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1);
        rx_in = 1'b1;
        tick(4);
        expect_lit("t3_release", 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, -1, -1);
        expect_lit("t3_55", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        pulse_rd();

        pulse_clr();
        expect_lit("t4_fclr", 1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        expect_lit("t4_ovr", 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        pulse_clr();
        expect_lit("t4_oclr", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b1, 9 * CPB + HALF - 2, -1);
        expect_lit("t4_rd33", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);

        send_frame(8'hFF, 1'b1, -1, 5 * CPB + 1);
        expect_lit("t5_pre", 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        expect_lit("t5_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rx_in = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        send_frame(8'h81, 1'b1, -1, -1);
        expect_lit("t5_81", 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);

        pulse_rd();
        send_frame(8'h7E, 1'b1, -1, 3 * CPB + 3);
        enable = 1'b0;
        tick(1);
        expect_lit("t6_abort", 1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
        rx_in = 1'b0;
        tick(10);
        expect_lit("t6_hold", 1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
        rx_in = 1'b1;
        tick(3);
        enable = 1'b1;
        tick(2);
        send_frame(8'h7E, 1'b1, -1, -1);
        expect_lit("t6_7e", 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
